// File: rtl/sprite_bounce_ctrl.sv
// sprite_bounce_ctrl: moves a fixed-size sprite window once per (divided) frame,
// bouncing off the active-area edges, and produces a registered hit flag plus
// sprite-local ROM coordinates for the current pixel.
module sprite_bounce_ctrl #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int SPR_W     = 16,
   parameter int SPR_H     = 128,
   parameter int STEP_X    = 2,
   parameter int STEP_Y    = 1,
   parameter int FRAME_DIV = 1,
   parameter int START_X   = 32,
   parameter int START_Y   = 128
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     move_en,
   input  logic                     vsync,
   input  logic                     display_on,
   input  logic [9:0]               hpos,
   input  logic [9:0]               vpos,
   output logic [9:0]               spr_x,
   output logic [9:0]               spr_y,
   output logic                     in_sprite,
   output logic [$clog2(SPR_W)-1:0] spr_u,
   output logic [$clog2(SPR_H)-1:0] spr_v,
   output logic                     frame_tick,
   output logic [1:0]               bounce
);

   localparam int U_W   = $clog2(SPR_W);
   localparam int V_W   = $clog2(SPR_H);
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

   logic             vs_q_reg;
   logic             frame_tick_reg;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_next;
   logic             do_update;
   logic [1:0]       bounce_reg;
   logic             in_sprite_reg;
   logic [U_W-1:0]   spr_u_reg;
   logic [V_W-1:0]   spr_v_reg;

   // Per-axis results gathered from the generate block (index 0 = X, 1 = Y).
   logic [9:0] pos_arr  [2];
   logic       edge_arr [2];
   logic       win_arr  [2];

   // Vsync falling-edge detector; history starts high so reset never fakes a tick.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vs_q_reg       <= 1'b1;
         frame_tick_reg <= 1'b0;
      end else begin
         vs_q_reg       <= vsync;
         frame_tick_reg <= vs_q_reg & ~vsync;
      end
   end

   // Frame divider: decides whether this tick moves the sprite.
   always_comb begin
      div_next  = div_reg;
      do_update = 1'b0;
      if (frame_tick_reg && move_en) begin
         if (div_reg == DIV_W'(FRAME_DIV - 1)) begin
            div_next  = '0;
            do_update = 1'b1;
         end else begin
            div_next  = div_reg + 1'b1;
         end
      end
   end

   // Divider register; move_en=0 leaves it untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_reg <= '0;
      end else begin
         div_reg <= div_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         localparam int AXIS_MAX   = (gi == 0) ? (H_ACTIVE - SPR_W) : (V_ACTIVE - SPR_H);
         localparam int AXIS_STEP  = (gi == 0) ? STEP_X : STEP_Y;
         localparam int AXIS_SIZE  = (gi == 0) ? SPR_W : SPR_H;
         localparam int AXIS_START = (gi == 0) ? START_X : START_Y;

         logic [9:0]  pos_reg;
         logic [9:0]  pos_next;
         dir_t        dir_reg;
         dir_t        dir_next;
         logic        edge_hit;
         logic [10:0] pos_ext;
         logic [10:0] fwd_ext;
         logic [10:0] coord_ext;

         // 11-bit copies so the wall compares cannot wrap.
         assign pos_ext   = {1'b0, pos_reg};
         assign fwd_ext   = pos_ext + 11'(AXIS_STEP);
         assign coord_ext = {1'b0, (gi == 0) ? hpos : vpos};

         // Next position/direction: clamp to the wall and reverse when reached.
         always_comb begin
            pos_next = pos_reg;
            dir_next = dir_reg;
            edge_hit = 1'b0;
            if (do_update) begin
               if (dir_reg == DIR_POS) begin
                  if (fwd_ext >= 11'(AXIS_MAX)) begin
                     pos_next = 10'(AXIS_MAX);
                     dir_next = DIR_NEG;
                     edge_hit = 1'b1;
                  end else begin
                     pos_next = fwd_ext[9:0];
                  end
               end else begin
                  if (pos_ext <= 11'(AXIS_STEP)) begin
                     pos_next = '0;
                     dir_next = DIR_POS;
                     edge_hit = 1'b1;
                  end else begin
                     pos_next = pos_reg - 10'(AXIS_STEP);
                  end
               end
            end
         end

         // Position/direction state; only changes on the tick cycle (inside vsync).
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               pos_reg <= 10'(AXIS_START);
               dir_reg <= DIR_POS;
            end else begin
               pos_reg <= pos_next;
               dir_reg <= dir_next;
            end
         end

         assign pos_arr[gi]  = pos_reg;
         assign edge_arr[gi] = edge_hit;
         assign win_arr[gi]  = (coord_ext >= pos_ext) &&
                               (coord_ext < (pos_ext + 11'(AXIS_SIZE)));
      end
   endgenerate

   // Bounce pulses land in the same cycle as the new position.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bounce_reg <= 2'b00;
      end else begin
         bounce_reg <= {edge_arr[1], edge_arr[0]};
      end
   end

   // Hit test and ROM address, one pipeline stage behind hpos/vpos.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_sprite_reg <= 1'b0;
         spr_u_reg     <= '0;
         spr_v_reg     <= '0;
      end else begin
         in_sprite_reg <= display_on && win_arr[0] && win_arr[1];
         spr_u_reg     <= U_W'(hpos - pos_arr[0]);
         spr_v_reg     <= V_W'(vpos - pos_arr[1]);
      end
   end

   assign spr_x      = pos_arr[0];
   assign spr_y      = pos_arr[1];
   assign frame_tick = frame_tick_reg;
   assign bounce     = bounce_reg;
   assign in_sprite  = in_sprite_reg;
   assign spr_u      = spr_u_reg;
   assign spr_v      = spr_v_reg;

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
// Scoreboard bench for sprite_bounce_ctrl. Instance a uses the default geometry;
// instance b uses a narrow field and FRAME_DIV=3 to reach a corner hit and the
// divider freeze quickly. Both share clock, reset, vsync and pixel inputs.
`timescale 1ns/1ps
module tb_sprite_bounce_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       move_en;
   logic       move_en_b;
   logic       vsync;
   logic       display_on;
   logic [9:0] hpos;
   logic [9:0] vpos;

   logic [9:0] spr_x_a, spr_y_a, spr_x_b, spr_y_b;
   logic       in_sprite_a, in_sprite_b, frame_tick_a, frame_tick_b;
   logic [3:0] spr_u_a, spr_u_b;
   logic [6:0] spr_v_a, spr_v_b;
   logic [1:0] bounce_a, bounce_b;

   int checks = 0;
   int errors = 0;
   int falls  = 0;

   always #5 clk = ~clk;

   sprite_bounce_ctrl dut_a (
      .clk(clk), .rst_n(rst_n), .move_en(move_en), .vsync(vsync),
      .display_on(display_on), .hpos(hpos), .vpos(vpos),
      .spr_x(spr_x_a), .spr_y(spr_y_a), .in_sprite(in_sprite_a),
      .spr_u(spr_u_a), .spr_v(spr_v_a), .frame_tick(frame_tick_a), .bounce(bounce_a)
   );

   sprite_bounce_ctrl #(
      .H_ACTIVE(19), .FRAME_DIV(3), .START_X(1), .START_Y(349)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .move_en(move_en_b), .vsync(vsync),
      .display_on(display_on), .hpos(hpos), .vpos(vpos),
      .spr_x(spr_x_b), .spr_y(spr_y_b), .in_sprite(in_sprite_b),
      .spr_u(spr_u_b), .spr_v(spr_v_b), .frame_tick(frame_tick_b), .bounce(bounce_b)
   );

   typedef struct {
      int         tick;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] bnc;
   } upd_t;

   typedef struct {
      string      name;
      logic       chk_pos;
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] bnc;
      logic       in;
      logic       chk_uv;
      logic [3:0] u;
      logic [6:0] v;
   } prb_t;

   upd_t qa[$];
   upd_t qb[$];
   prb_t qp[$];

   function automatic void cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // ---------------- monitors ----------------
   logic probe   = 1'b0;
   logic probe_d = 1'b0;
   always @(posedge clk) probe_d <= probe;

   // Probe monitor: compares hit/state outputs one cycle after the inputs were set.
   prb_t pm;
   always @(negedge clk) begin
      if (probe_d) begin
         if (qp.size() == 0) begin
            errors++;
            $display("FAIL probe queue: got empty expected an entry");
         end else begin
            pm = qp.pop_front();
            cmp({pm.name, " in_sprite"}, int'(in_sprite_a), int'(pm.in));
            if (pm.in || pm.chk_uv) begin
               cmp({pm.name, " spr_u"}, int'(spr_u_a), int'(pm.u));
               cmp({pm.name, " spr_v"}, int'(spr_v_a), int'(pm.v));
            end
            if (pm.chk_pos) begin
               cmp({pm.name, " spr_x"}, int'(spr_x_a), int'(pm.x));
               cmp({pm.name, " spr_y"}, int'(spr_y_a), int'(pm.y));
               cmp({pm.name, " bounce"}, int'(bounce_a), int'(pm.bnc));
            end
         end
      end
   end

   // Update monitor for instance a: checks the cycle after each frame_tick.
   int   tcnt_a = 0, pulses_a = 0;
   logic ft_d_a = 1'b0, bchk_a = 1'b0;
   upd_t ea;
   always @(negedge clk) begin
      if (!rst_n) begin
         tcnt_a = 0; ft_d_a = 1'b0; bchk_a = 1'b0;
      end else begin
         if (bchk_a) begin
            cmp("a bounce pulse width", int'(bounce_a), 0);
            bchk_a = 1'b0;
         end
         if (ft_d_a) begin
            tcnt_a++;
            cmp("a frame_tick width", int'(frame_tick_a), 0);
            while (qa.size() > 0 && qa[0].tick < tcnt_a) begin
               ea = qa.pop_front();
               errors++;
               $display("FAIL a tick %0d: got no check expected one", ea.tick);
            end
            if (qa.size() > 0 && qa[0].tick == tcnt_a) begin
               ea = qa.pop_front();
               cmp($sformatf("a tick %0d spr_x", ea.tick), int'(spr_x_a), int'(ea.x));
               cmp($sformatf("a tick %0d spr_y", ea.tick), int'(spr_y_a), int'(ea.y));
               cmp($sformatf("a tick %0d bounce", ea.tick), int'(bounce_a), int'(ea.bnc));
               bchk_a = (ea.bnc != 2'b00);
            end
         end
         ft_d_a = (frame_tick_a === 1'b1);
      end
      if (frame_tick_a === 1'b1) pulses_a++;
   end

   // Update monitor for instance b.
   int   tcnt_b = 0, pulses_b = 0;
   logic ft_d_b = 1'b0, bchk_b = 1'b0;
   upd_t eb;
   always @(negedge clk) begin
      if (!rst_n) begin
         tcnt_b = 0; ft_d_b = 1'b0; bchk_b = 1'b0;
      end else begin
         if (bchk_b) begin
            cmp("b bounce pulse width", int'(bounce_b), 0);
            bchk_b = 1'b0;
         end
         if (ft_d_b) begin
            tcnt_b++;
            while (qb.size() > 0 && qb[0].tick < tcnt_b) begin
               eb = qb.pop_front();
               errors++;
               $display("FAIL b tick %0d: got no check expected one", eb.tick);
            end
            if (qb.size() > 0 && qb[0].tick == tcnt_b) begin
               eb = qb.pop_front();
               cmp($sformatf("b tick %0d spr_x", eb.tick), int'(spr_x_b), int'(eb.x));
               cmp($sformatf("b tick %0d spr_y", eb.tick), int'(spr_y_b), int'(eb.y));
               cmp($sformatf("b tick %0d bounce", eb.tick), int'(bounce_b), int'(eb.bnc));
               bchk_b = (eb.bnc != 2'b00);
            end
         end
         ft_d_b = (frame_tick_b === 1'b1);
      end
      if (frame_tick_b === 1'b1) pulses_b++;
   end

   // ---------------- stimulus ----------------
   task automatic probe_hit(input string nm, input logic [9:0] h, input logic [9:0] v,
                            input logic d, input logic ein, input logic [3:0] eu,
                            input logic [6:0] ev);
      prb_t p;
      @(posedge clk); #1;
      hpos = h; vpos = v; display_on = d;
      p.name = nm; p.chk_pos = 1'b0; p.x = '0; p.y = '0; p.bnc = '0;
      p.in = ein; p.chk_uv = 1'b0; p.u = eu; p.v = ev;
      qp.push_back(p);
      probe = 1'b1;
      @(posedge clk); #1;
      probe = 1'b0;
   endtask

   task automatic probe_state(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                              input logic [1:0] eb2, input logic ein, input logic [3:0] eu,
                              input logic [6:0] ev);
      prb_t p;
      @(posedge clk); #1;
      p.name = nm; p.chk_pos = 1'b1; p.x = ex; p.y = ey; p.bnc = eb2;
      p.in = ein; p.chk_uv = 1'b1; p.u = eu; p.v = ev;
      qp.push_back(p);
      probe = 1'b1;
      @(posedge clk); #1;
      probe = 1'b0;
   endtask

   task automatic vs_fall();
      @(posedge clk); #1;
      vsync = 1'b0;
      falls++;
      repeat (3) @(posedge clk);
      #1;
      vsync = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic push_a(input int t, input int x, input int y, input logic [1:0] b);
      upd_t e;
      e.tick = t; e.x = 10'(x); e.y = 10'(y); e.bnc = b;
      qa.push_back(e);
   endtask

   task automatic push_b(input int t, input int x, input int y, input logic [1:0] b);
      upd_t e;
      e.tick = t; e.x = 10'(x); e.y = 10'(y); e.bnc = b;
      qb.push_back(e);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; move_en = 1'b1; move_en_b = 1'b1; vsync = 1'b1;
      display_on = 1'b1; hpos = 10'd40; vpos = 10'd130;
      repeat (2) @(posedge clk);
      // Inputs say "inside" but reset must hold every output at its reset value.
      probe_state("reset state", 10'd32, 10'd128, 2'b00, 1'b0, 4'd0, 7'd0);
      rst_n = 1'b1;
      probe_state("release state", 10'd32, 10'd128, 2'b00, 1'b1, 4'd8, 7'd2);

      probe_hit("hit inside",      10'd40, 10'd130, 1'b1, 1'b1, 4'd8,  7'd2);
      probe_hit("right edge out",  10'd48, 10'd130, 1'b1, 1'b0, 4'd0,  7'd0);
      probe_hit("right edge in",   10'd47, 10'd130, 1'b1, 1'b1, 4'd15, 7'd2);
      probe_hit("left edge out",   10'd31, 10'd130, 1'b1, 1'b0, 4'd0,  7'd0);
      probe_hit("top-left corner", 10'd32, 10'd128, 1'b1, 1'b1, 4'd0,  7'd0);
      probe_hit("bottom edge in",  10'd40, 10'd255, 1'b1, 1'b1, 4'd8,  7'd127);
      probe_hit("bottom edge out", 10'd40, 10'd256, 1'b1, 1'b0, 4'd0,  7'd0);
      probe_hit("top edge out",    10'd40, 10'd127, 1'b1, 1'b0, 4'd0,  7'd0);
      probe_hit("display off",     10'd40, 10'd130, 1'b0, 1'b0, 4'd0,  7'd0);

      // Instance a: 2 px / 1 line per frame from (32,128); Y wall at 352, X wall at 624.
      push_a(1, 34, 129, 2'b00);
      push_a(2, 36, 130, 2'b00);
      push_a(3, 38, 131, 2'b00);
      push_a(223, 478, 351, 2'b00);
      push_a(224, 480, 352, 2'b10);
      push_a(225, 482, 351, 2'b00);
      push_a(295, 622, 281, 2'b00);
      push_a(296, 624, 280, 2'b01);
      push_a(297, 622, 279, 2'b00);
      push_a(300, 622, 279, 2'b00);
      push_a(302, 622, 279, 2'b00);

      // Instance b: X wall at 3, Y wall at 352, update every third tick, frozen on ticks 5..9.
      push_b(3, 3, 350, 2'b01);
      push_b(4, 3, 350, 2'b00);
      push_b(7, 3, 350, 2'b00);
      push_b(9, 3, 350, 2'b00);
      push_b(10, 3, 350, 2'b00);
      push_b(11, 1, 351, 2'b00);
      push_b(14, 0, 352, 2'b11);
      push_b(17, 2, 351, 2'b00);
      push_b(20, 3, 350, 2'b01);

      for (int t = 1; t <= 3; t++) vs_fall();

      probe_hit("moved corner in", 10'd38, 10'd131, 1'b1, 1'b1, 4'd0, 7'd0);
      probe_hit("moved left out",  10'd37, 10'd131, 1'b1, 1'b0, 4'd0, 7'd0);

      for (int t = 4; t <= 302; t++) begin
         move_en_b = !(t >= 5 && t <= 9);
         move_en   = (t < 298);
         vs_fall();
      end

      // Reset lands on the very cycle the tick would have moved the sprite.
      move_en = 1'b1;
      hpos = 10'd40; vpos = 10'd130; display_on = 1'b1;
      @(posedge clk); #1;
      vsync = 1'b0;
      falls++;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      vsync = 1'b1;
      probe_state("mid-frame reset", 10'd32, 10'd128, 2'b00, 1'b1, 4'd8, 7'd2);
      repeat (3) @(posedge clk);
      #1;

      cmp("a frame_tick count", pulses_a, falls);
      cmp("b frame_tick count", pulses_b, falls);
      cmp("a queue left", qa.size(), 0);
      cmp("b queue left", qb.size(), 0);
      cmp("probe queue left", qp.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
